// File: rtl/cond_flag_eval_pkg.sv
// -----------------------------------------------------------------------------
// cond_flag_eval_pkg
// Shared constants for the compare-flag / conditional-branch path:
//   - 4-bit condition codes (COND_EQ .. COND_NV)
//   - branch FSM state encoding
//   - bit positions of N/Z/C/V inside the 4-bit flag vector {N,Z,C,V}
//   - sequential PC increment
// -----------------------------------------------------------------------------
package cond_flag_eval_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_LO = 4'h2;
  localparam logic [3:0] COND_HS = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  localparam int PC_INC = 4;

endpackage

// File: rtl/cond_flag_eval_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code evaluator. C is a borrow flag
// (1 = minuend < subtrahend unsigned), so LO tests C set and HS tests C clear.
// Ports:
//   cond_i  [3:0]  condition code
//   nzcv_i  [3:0]  flags {N,Z,C,V}
//   taken_o        condition true
// -----------------------------------------------------------------------------
module cond_eval
  import cond_flag_eval_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       taken_o
);

  logic n, z, c, v;

  assign n = nzcv_i[NZCV_N];
  assign z = nzcv_i[NZCV_Z];
  assign c = nzcv_i[NZCV_C];
  assign v = nzcv_i[NZCV_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_LO: taken_o = c;
      COND_HS: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = !c && !z;
      COND_LS: taken_o = c || z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = z || (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_eval.sv
// -----------------------------------------------------------------------------
// cond_flag_eval
// Latches N/Z/C/V from the compare unit and resolves conditional branches
// handed over through a valid/ready handshake. A branch that arrives while a
// compare is still in flight waits for that compare's flags. The registered
// result carries taken/not-taken and the redirect PC.
//
// Optional build macro: COND_FLAG_TIMEOUT_EN
//   defined   - a branch stuck in WAIT for TIMEOUT cycles completes with
//               res_err=1, res_taken=0, res_next_pc=br_pc+4
//   undefined - WAIT is held until flags arrive; res_err is tied to 0
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flag_wr, flag_n/z/c/v      compare result strobe and flags
//   cmp_pending                a compare is in flight
//   br_valid/br_ready          request handshake
//   br_cond, br_pc, br_target  branch request payload
//   res_valid/res_ready        result handshake
//   res_taken, res_next_pc     result payload
//   res_err                    timeout error
//   nzcv                       architectural flag register {N,Z,C,V}
//
// state   | meaning
// IDLE    | ready for a branch request
// WAIT    | branch captured, waiting for pending compare flags
// RESP    | result presented, waiting for res_ready
// -----------------------------------------------------------------------------
module cond_flag_eval
  import cond_flag_eval_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flag_wr,
  input  logic          flag_n,
  input  logic          flag_z,
  input  logic          flag_c,
  input  logic          flag_v,
  input  logic          cmp_pending,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] br_target,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_taken,
  output logic [AW-1:0] res_next_pc,
  output logic          res_err,
  output logic [3:0]    nzcv
);

  state_e        state_q, state_d;
  logic [3:0]    nzcv_q, nzcv_d;
  logic [3:0]    cond_q, cond_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] target_q, target_d;
  logic          taken_q, taken_d;
  logic [AW-1:0] next_pc_q, next_pc_d;

  logic [3:0]    flags_in;
  logic [3:0]    flags_fwd;
  logic [3:0]    cond_sel;
  logic [AW-1:0] pc_sel;
  logic [AW-1:0] target_sel;
  logic [AW-1:0] pc_seq;
  logic          eval_taken;

  assign flags_in  = {flag_n, flag_z, flag_c, flag_v};
  // Same-cycle flags bypass the register so a compare and its branch can meet.
  assign flags_fwd = flag_wr ? flags_in : nzcv_q;

  // In IDLE the live request is evaluated; in WAIT the captured one.
  assign cond_sel   = (state_q == ST_IDLE) ? br_cond   : cond_q;
  assign pc_sel     = (state_q == ST_IDLE) ? br_pc     : pc_q;
  assign target_sel = (state_q == ST_IDLE) ? br_target : target_q;
  assign pc_seq     = pc_sel + AW'(PC_INC);

  cond_eval u_cond_eval (
    .cond_i  (cond_sel),
    .nzcv_i  (flags_fwd),
    .taken_o (eval_taken)
  );

`ifdef COND_FLAG_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d   = state_q;
    nzcv_d    = flag_wr ? flags_in : nzcv_q;
    cond_d    = cond_q;
    pc_d      = pc_q;
    target_d  = target_q;
    taken_d   = taken_q;
    next_pc_d = next_pc_q;
`ifdef COND_FLAG_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond;
          pc_d     = br_pc;
          target_d = br_target;
          if (cmp_pending && !flag_wr) begin
            state_d = ST_WAIT;
`ifdef COND_FLAG_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            taken_d   = eval_taken;
            next_pc_d = eval_taken ? target_sel : pc_seq;
            state_d   = ST_RESP;
`ifdef COND_FLAG_TIMEOUT_EN
            err_d     = 1'b0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (flag_wr) begin
          taken_d   = eval_taken;
          next_pc_d = eval_taken ? target_sel : pc_seq;
          state_d   = ST_RESP;
`ifdef COND_FLAG_TIMEOUT_EN
          err_d     = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          taken_d   = 1'b0;
          next_pc_d = pc_seq;
          err_d     = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d     = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      nzcv_q    <= '0;
      cond_q    <= '0;
      pc_q      <= '0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      next_pc_q <= '0;
`ifdef COND_FLAG_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      nzcv_q    <= nzcv_d;
      cond_q    <= cond_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      next_pc_q <= next_pc_d;
`ifdef COND_FLAG_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign br_ready    = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_RESP);
  assign res_taken   = taken_q;
  assign res_next_pc = next_pc_q;
  assign nzcv        = nzcv_q;
`ifdef COND_FLAG_TIMEOUT_EN
  assign res_err     = err_q;
`else
  assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cond_flag_eval.sv
// -----------------------------------------------------------------------------
// tb_cond_flag_eval
// Directed bench for cond_flag_eval. Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_cond_flag_eval;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flag_wr, flag_n, flag_z, flag_c, flag_v;
  logic          cmp_pending;
  logic          br_valid;
  logic          br_ready;
  logic [3:0]    br_cond;
  logic [AW-1:0] br_pc, br_target;
  logic          res_valid;
  logic          res_ready;
  logic          res_taken;
  logic [AW-1:0] res_next_pc;
  logic          res_err;
  logic [3:0]    nzcv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_flag_eval #(.AW(AW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flag_wr     (flag_wr),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .cmp_pending (cmp_pending),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_cond     (br_cond),
    .br_pc       (br_pc),
    .br_target   (br_target),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_taken   (res_taken),
    .res_next_pc (res_next_pc),
    .res_err     (res_err),
    .nzcv        (nzcv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    {flag_n, flag_z, flag_c, flag_v} = f;
    flag_wr = 1'b1;
    tick();
    flag_wr = 1'b0;
    chk("nzcv_load", {28'd0, nzcv}, {28'd0, f});
  endtask

  // Issue one branch with no pending compare and retire its result.
  task automatic branch(input string tag, input logic [3:0] cond,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic exp_taken, input logic [31:0] exp_pc);
    br_valid = 1'b1; br_cond = cond; br_pc = pc; br_target = tgt;
    tick();
    br_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_taken"}, {31'd0, res_taken}, {31'd0, exp_taken});
    chk({tag, "_pc"}, res_next_pc, exp_pc);
    chk({tag, "_err"}, {31'd0, res_err}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, res_valid}, 32'd0);
  endtask

  typedef struct {
    logic [3:0] cond;
    logic       taken;
  } vec_t;

  initial begin
    vec_t v1000[10];
    vec_t v0100[5];
    vec_t v0011[5];

    rst_n = 1'b0; flag_wr = 0; flag_n = 0; flag_z = 0; flag_c = 0; flag_v = 0;
    cmp_pending = 0; br_valid = 0; br_cond = 0; br_pc = 0; br_target = 0;
    res_ready = 0;
    #1;
    tick(); tick();
    chk("rst_nzcv", {28'd0, nzcv}, 32'd0);
    chk("rst_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_err", {31'd0, res_err}, 32'd0);
    chk("rst_taken", {31'd0, res_taken}, 32'd0);
    chk("rst_pc", res_next_pc, 32'd0);
    rst_n = 1'b1;

    // Equal compare, result held while res_ready is low.
    set_flags(4'b0100);
    br_valid = 1; br_cond = 4'h0; br_pc = 32'h100; br_target = 32'h200;
    tick();
    br_valid = 0;
    chk("eq_valid", {31'd0, res_valid}, 32'd1);
    chk("eq_taken", {31'd0, res_taken}, 32'd1);
    chk("eq_pc", res_next_pc, 32'h200);
    chk("eq_ready", {31'd0, br_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      // Flags written during RESP update nzcv but not the held result.
      if (i == 2) begin {flag_n, flag_z, flag_c, flag_v} = 4'b0000; flag_wr = 1; end
      tick();
      flag_wr = 0;
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_taken", {31'd0, res_taken}, 32'd1);
      chk("hold_pc", res_next_pc, 32'h200);
    end
    chk("resp_nzcv", {28'd0, nzcv}, 32'd0);
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("eq_done", {31'd0, res_valid}, 32'd0);
    chk("eq_idle", {31'd0, br_ready}, 32'd1);

    // -1 vs 1: N=1, Z=0, C=0 (no borrow unsigned), V=0.
    set_flags(4'b1000);
    branch("lt", 4'hB, 32'h300, 32'h400, 1'b1, 32'h400);
    branch("lo", 4'h2, 32'h300, 32'h400, 1'b0, 32'h304);
    branch("ge", 4'hA, 32'h300, 32'h400, 1'b0, 32'h304);
    branch("hs", 4'h3, 32'h300, 32'h400, 1'b1, 32'h400);

    v1000 = '{'{4'h4,1'b1}, '{4'h5,1'b0}, '{4'h8,1'b1}, '{4'h9,1'b0},
              '{4'hC,1'b0}, '{4'hD,1'b1}, '{4'hE,1'b1}, '{4'h6,1'b0},
              '{4'h7,1'b1}, '{4'h1,1'b1}};
    foreach (v1000[i])
      branch("t1000", v1000[i].cond, 32'h1000, 32'h2000, v1000[i].taken,
             v1000[i].taken ? 32'h2000 : 32'h1004);

    set_flags(4'b0100);
    v0100 = '{'{4'h1,1'b0}, '{4'hC,1'b0}, '{4'hD,1'b1}, '{4'h8,1'b0}, '{4'h9,1'b1}};
    foreach (v0100[i])
      branch("t0100", v0100[i].cond, 32'h40, 32'h80, v0100[i].taken,
             v0100[i].taken ? 32'h80 : 32'h44);

    set_flags(4'b0011);
    v0011 = '{'{4'h2,1'b1}, '{4'h6,1'b1}, '{4'hA,1'b0}, '{4'hB,1'b1}, '{4'h8,1'b0}};
    foreach (v0011[i])
      branch("t0011", v0011[i].cond, 32'h50, 32'h90, v0011[i].taken,
             v0011[i].taken ? 32'h90 : 32'h54);

    // Pending stall: stale Z=1 would make NE not taken.
    set_flags(4'b0100);
    cmp_pending = 1;
    br_valid = 1; br_cond = 4'h1; br_pc = 32'h500; br_target = 32'h600;
    tick();
    br_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("wait_ready", {31'd0, br_ready}, 32'd0);
      chk("wait_valid", {31'd0, res_valid}, 32'd0);
      if (i < 4) tick();
    end
    {flag_n, flag_z, flag_c, flag_v} = 4'b0000;
    flag_wr = 1; cmp_pending = 0;
    tick();
    flag_wr = 0;
    chk("stall_valid", {31'd0, res_valid}, 32'd1);
    chk("stall_taken", {31'd0, res_taken}, 32'd1);
    chk("stall_pc", res_next_pc, 32'h600);
    chk("stall_nzcv", {28'd0, nzcv}, 32'd0);
    res_ready = 1; tick(); res_ready = 0;
    chk("stall_done", {31'd0, res_valid}, 32'd0);

    // Flags arriving in the accept cycle: forwarded, no WAIT.
    cmp_pending = 1;
    {flag_n, flag_z, flag_c, flag_v} = 4'b0100; flag_wr = 1;
    br_valid = 1; br_cond = 4'h0; br_pc = 32'h700; br_target = 32'h800;
    tick();
    br_valid = 0; flag_wr = 0; cmp_pending = 0;
    chk("fwd_valid", {31'd0, res_valid}, 32'd1);
    chk("fwd_taken", {31'd0, res_taken}, 32'd1);
    chk("fwd_pc", res_next_pc, 32'h800);
    res_ready = 1; tick(); res_ready = 0;

    // PC wrap.
    branch("wrap_nv", 4'hF, 32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0);
    branch("wrap_al", 4'hE, 32'hFFFF_FFFC, 32'h10, 1'b1, 32'h10);

    // Reset while in WAIT.
    set_flags(4'b1111);
    cmp_pending = 1;
    br_valid = 1; br_cond = 4'h0; br_pc = 32'h900; br_target = 32'hA00;
    tick();
    br_valid = 0;
    chk("rw_wait", {31'd0, br_ready}, 32'd0);
    rst_n = 0;
    tick();
    chk("rw_valid", {31'd0, res_valid}, 32'd0);
    chk("rw_ready", {31'd0, br_ready}, 32'd1);
    chk("rw_nzcv", {28'd0, nzcv}, 32'd0);
    rst_n = 1; cmp_pending = 0;
    tick();
    chk("rw_after", {31'd0, res_valid}, 32'd0);

    // Pending compare that never resolves.
    cmp_pending = 1;
    br_valid = 1; br_cond = 4'hE; br_pc = 32'hB00; br_target = 32'hC00;
    tick();
    br_valid = 0;
`ifdef COND_FLAG_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("to_early", {31'd0, res_valid}, 32'd0);
    tick();
    chk("to_valid", {31'd0, res_valid}, 32'd1);
    chk("to_err", {31'd0, res_err}, 32'd1);
    chk("to_taken", {31'd0, res_taken}, 32'd0);
    chk("to_pc", res_next_pc, 32'hB04);
    cmp_pending = 0;
    res_ready = 1; tick(); res_ready = 0;
    chk("to_done", {31'd0, res_valid}, 32'd0);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("hold_wait_valid", {31'd0, res_valid}, 32'd0);
    chk("hold_wait_err", {31'd0, res_err}, 32'd0);
    {flag_n, flag_z, flag_c, flag_v} = 4'b0000; flag_wr = 1; cmp_pending = 0;
    tick();
    flag_wr = 0;
    chk("late_valid", {31'd0, res_valid}, 32'd1);
    chk("late_taken", {31'd0, res_taken}, 32'd1);
    chk("late_pc", res_next_pc, 32'hC00);
    res_ready = 1; tick(); res_ready = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_flag_eval.md
Name: cond_flag_eval

Overview:
- Consumer end of the compare path: latches the N/Z/C/V flags produced by the r2 − r3 compare unit into an architectural flag register.
- Accepts conditional-branch requests through a valid/ready handshake and evaluates a 4-bit condition code against the flags.
- Returns a registered taken/not-taken result with the selected next PC.
- Sits between the compare/ALU stage and the fetch-redirect logic; stalls branches while a compare is still in flight.

Parameters:
- AW, 32, width of the branch PC and target buses
- TIMEOUT, 16, cycles to wait for pending flags before forcing an error result (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- flag_wr  in  1  compare result valid this cycle; load flags
- flag_n  in  1  negative flag (difference bit 31)
- flag_z  in  1  zero flag (difference == 0)
- flag_c  in  1  borrow flag (difference bit 32; 1 = r2 < r3 unsigned)
- flag_v  in  1  signed overflow flag
- cmp_pending  in  1  a compare has issued whose flags are not yet written
- br_valid  in  1  branch request valid
- br_ready  out  1  block can accept a request
- br_cond  in  4  condition code
- br_pc  in  AW  PC of the branch
- br_target  in  AW  taken target
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts the result
- res_taken  out  1  condition true
- res_next_pc  out  AW  br_target if taken, else br_pc + 4
- res_err  out  1  timeout error (always 0 without the optional feature)
- nzcv  out  4  current flag register {N,Z,C,V}

Behaviour:
- Reset (rst_n low at a clk edge): nzcv=0000, state=IDLE, br_ready=1, res_valid=0, res_taken=0, res_next_pc=0, res_err=0. Any captured request is discarded; a mid-operation reset drops the in-flight branch with no result issued.
- Flag register: loads {flag_n, flag_z, flag_c, flag_v} on any cycle with flag_wr=1, in every state.
- Forwarded flags: the flags used for evaluation in a cycle are the incoming flags when flag_wr=1, otherwise nzcv.
- State machine:
  - IDLE: br_ready=1. On br_valid, capture br_cond, br_pc and br_target.
    - If cmp_pending=1 and flag_wr=0, go to WAIT.
    - Otherwise evaluate with forwarded flags, register the result, and go to RESP.
  - WAIT: br_ready=0. On flag_wr=1, evaluate with the forwarded (incoming) flags and go to RESP.
  - RESP: br_ready=0, res_valid=1. Outputs hold stable until res_ready=1, then go to IDLE. No new accept occurs in that same cycle.
- Latency: accept-to-res_valid is 1 cycle when no compare is pending. With a pending compare it is 1 cycle after the flag_wr cycle.
- Throughput: at most one branch every 2 cycles.
- Condition codes (C is borrow, not carry):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 LO: C
  - 3 HS: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: !C & !Z
  - 9 LS: C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & (N==V)
  - D LE: Z | (N!=V)
  - E AL: 1
  - F NV: 0
- Arithmetic: br_pc + 4 is computed modulo 2^AW; 0xFFFFFFFC wraps to 0.
- Simultaneous events: flag_wr together with acceptance means the new flags are used and there is no WAIT. flag_wr during RESP updates nzcv only; the held result is unchanged.

Optional Feature:
- Macro: COND_FLAG_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT−1 without flag_wr, go to RESP with res_err=1, res_taken=0, res_next_pc=br_pc+4.
  - A flag_wr in the expiry cycle wins (normal result).
- Undefined: no counter; WAIT is held indefinitely; res_err is tied to 0.

Decomposition:
- Shared package:
  - 4-bit condition-code constants (COND_EQ … COND_NV)
  - FSM state enum (IDLE, WAIT, RESP)
  - NZCV bit-index constants
  - PC increment constant 4
- Sub-module: cond_eval, combinational, taking cond[3:0] and nzcv[3:0] and producing a 1-bit taken. It is reused by future predicated-execution logic.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles, nzcv=0, br_ready=1, res_valid=0, res_err=0.
- Equal compare: flag_wr with NZCV=0100; one cycle later br_cond=EQ, br_pc=0x100, br_target=0x200 → next cycle res_valid=1, res_taken=1, res_next_pc=0x200. Holding res_ready=0 for 3 cycles keeps the outputs stable.
- Signed vs unsigned: flags from −1 vs 1 give NZCV=1000. LT → taken. LO → not taken, res_next_pc=br_pc+4. GE and HS → the complements.
- Pending stall: cmp_pending=1 at accept of NE → state WAIT, br_ready=0 for 5 cycles. Then flag_wr with Z=0 → res_taken=1 the following cycle. Repeat with flag_wr in the accept cycle → no WAIT.
- Wrap and reset: br_pc=0xFFFFFFFC with NV → res_next_pc=0. Asserting rst_n low while in WAIT → IDLE, no res_valid, nzcv=0.
- COND_FLAG_TIMEOUT_EN, TIMEOUT=16: pending never resolves → res_valid after 16 WAIT cycles with res_err=1 and res_taken=0.
